// File: rtl/fnd_scan_mux.sv
// Time-multiplexes four FND digit codes onto one shared segment bus with dark gaps between slots.
// Define FND_LZB_EN to blank leading zero digits (code 8'hBF) in the thousands, hundreds and tens slots.
module fnd_scan_mux #(
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] seg1,
    input  logic [7:0] seg10,
    input  logic [7:0] seg100,
    input  logic [7:0] seg1000,
    output logic [7:0] seg_out,
    output logic [3:0] dig_n,
    output logic       frame_tick
);

    localparam int CNT_MAX = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] ON_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
    localparam logic [7:0]    ZERO_CODE = 8'hBF;

    typedef enum logic {ON, DEAD} state_t;

    state_t        state;
    logic [1:0]    idx;
    logic [1:0]    nxt_idx;
    logic [CW-1:0] cnt;
    logic [7:0]    snap [4];
    logic [7:0]    entry_seg;
    logic          entry_blank;
`ifdef FND_LZB_EN
    logic [3:0]    blank;
`endif

    assign nxt_idx = idx + 2'd1;

    // The ones slot shows the live input because its capture happens on the same edge.
    always_comb begin
        entry_seg   = (nxt_idx == 2'd0) ? seg1 : snap[nxt_idx];
        entry_blank = 1'b0;
`ifdef FND_LZB_EN
        entry_blank = blank[nxt_idx];
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= DEAD;
            idx        <= 2'd3;
            cnt        <= '0;
            for (int i = 0; i < 4; i++) begin
                snap[i] <= 8'h00;
            end
`ifdef FND_LZB_EN
            blank      <= 4'b0000;
`endif
            seg_out    <= 8'h00;
            dig_n      <= 4'hF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            case (state)
                DEAD: begin
                    if (cnt == DEAD_LAST) begin
                        state <= ON;
                        idx   <= nxt_idx;
                        cnt   <= '0;
                        if (nxt_idx == 2'd0) begin
                            snap[0]    <= seg1;
                            snap[1]    <= seg10;
                            snap[2]    <= seg100;
                            snap[3]    <= seg1000;
                            frame_tick <= 1'b1;
`ifdef FND_LZB_EN
                            // A digit is blanked only if it and every higher digit are zero.
                            blank[0] <= 1'b0;
                            blank[1] <= (seg1000 == ZERO_CODE) && (seg100 == ZERO_CODE) &&
                                        (seg10 == ZERO_CODE);
                            blank[2] <= (seg1000 == ZERO_CODE) && (seg100 == ZERO_CODE);
                            blank[3] <= (seg1000 == ZERO_CODE);
`endif
                        end
                        if (entry_blank) begin
                            dig_n   <= 4'hF;
                            seg_out <= 8'h00;
                        end else begin
                            dig_n   <= ~(4'b0001 << nxt_idx);
                            seg_out <= entry_seg;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ON: begin
                    if (cnt == ON_LAST) begin
                        state   <= DEAD;
                        cnt     <= '0;
                        dig_n   <= 4'hF;
                        seg_out <= 8'h00;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= DEAD;
                    cnt     <= '0;
                    dig_n   <= 4'hF;
                    seg_out <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: doc/fnd_scan_mux.md
FND_SCAN_MUX -- requirements
Module: fnd_scan_mux

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: ON-slot length per digit in CLK cycles; legal range 2..2^20.
REQ-002 SHALL have parameter DEAD_CYC, default 16: all-digits-off gap between slots in CLK cycles; legal range 1..255.
REQ-003 SHALL have port CLK, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports seg1, seg10, seg100, seg1000, input, 8 each: active-high segment codes for ones, tens, hundreds and thousands digits from the FND decoders.
REQ-006 SHALL have port seg_out, output, 8: shared active-high segment bus.
REQ-007 SHALL have port dig_n, output, 4: active-low digit enables; bit0 = ones, bit3 = thousands.
REQ-008 SHALL have port frame_tick, output, 1: one-cycle pulse at the start of each frame.

Function
REQ-009 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-010 SHALL implement FSM states ON and DEAD, a 2-bit digit index idx, and a cycle counter sized to max(SCAN_DIV, DEAD_CYC).
REQ-011 In DEAD, SHALL drive dig_n=4'hF and seg_out=8'h00 for exactly DEAD_CYC cycles.
REQ-012 On DEAD expiry, SHALL set idx to (idx+1) mod 4 and enter ON; idx wraps 3->0.
REQ-013 In ON, SHALL drive dig_n with only bit idx low and seg_out = snapshot[idx] for exactly SCAN_DIV cycles, then enter DEAD.
REQ-014 On entry to ON with idx=0, SHALL capture all four seg inputs into snapshot registers in the same cycle; snapshot[0] is displayed in that cycle.
REQ-015 Input changes at any other time SHALL NOT affect seg_out until the next capture; no intra-frame tearing.
REQ-016 SHALL assert frame_tick for exactly the first cycle of ON with idx=0; it SHALL be 0 otherwise.
REQ-017 Frame period SHALL be exactly 4*(SCAN_DIV+DEAD_CYC) cycles; scan order SHALL be ones, tens, hundreds, thousands.

Reset
REQ-018 While RST=0, SHALL hold state=DEAD, idx=3, counter=0, snapshots=8'h00, dig_n=4'hF, seg_out=8'h00 and frame_tick=0, independent of CLK.
REQ-019 After RST rises, first ON slot SHALL be idx=0 after DEAD_CYC cycles, with capture and frame_tick.
REQ-020 Reset asserted mid-slot SHALL force reset values immediately; no partial slot completes.

Configuration
REQ-021 Macro FND_LZB_EN defined: SHALL blank leading zeros (code 8'hBF) in snapshot; thousands is blanked if 8'hBF; hundreds if thousands is blanked and it is 8'hBF; tens likewise; ones is never blanked.
REQ-022 A blanked digit's ON slot SHALL keep dig_n=4'hF and seg_out=8'h00, with slot timing unchanged.
REQ-023 Macro FND_LZB_EN undefined: SHALL display all four digits unconditionally; no blanking logic is synthesized.

Verification (SCAN_DIV=4, DEAD_CYC=2)
REQ-024 Reset release -> 2 cycles dig_n=F/seg_out=00, then dig_n=1110, seg_out=seg1 for 4 cycles, with frame_tick high in the first of those cycles only.
REQ-025 Free-run with seg1..seg1000 = 11,22,33,44 -> slot pattern 1110/11, 1101/22, 1011/33, 0111/44, each separated by 2 dark cycles; frame_tick period 24.
REQ-026 seg10 changed 22->55 during the hundreds slot -> tens slot shows 22 this frame and 55 only after the next frame_tick.
REQ-027 FND_LZB_EN with codes for 0,0,4,2 (seg1000=BF, seg100=BF) -> thousands and hundreds slots dark, tens and ones lit; all four inputs BF -> only ones lit; macro undefined -> all four lit.
REQ-028 RST driven low mid-ON with no CLK edge -> dig_n=F, seg_out=00 immediately; after release, behaviour matches REQ-024.
